arb4_ctrl: RTL and testbench
============================

Name: arb4_ctrl

Overview:
- Sequential 4-requester arbiter that shares one resource (a single-owner datapath port) between four clients.
- Fixed priority gives the highest index precedence: req[3] > req[2] > req[1] > req[0]. Optional round-robin rotation is available.
- A grant is held while its owner keeps requesting, up to a bounded hold time.
- Each hand-over is followed by one dead cycle so the resource can turn around.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 = unlimited. Legal range 0..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  level request per client; bit i = client i.
- rr_en  input  1  1 = round-robin priority, 0 = fixed priority (highest index wins).
- gnt  output  4  registered one-hot grant; all zeros when idle or in the dead cycle.
- gnt_id  output  2  index of the current owner; valid only when busy=1.
- busy  output  1  1 while any gnt bit is set.
- expired  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst=1 at an edge forces:
  - state=IDLE, gnt=0, gnt_id=0, busy=0, expired=0;
  - hold_cnt=0, last_id=0.
  - This applies mid-grant too: the grant drops the cycle after rst is sampled, and no dead cycle is inserted.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req!=0 at edge T, gnt = one-hot(winner) from T+1. Latency is one cycle.
  - Enter GRANT; hold_cnt=1; last_id=winner.
  - If req=0, stay in IDLE.
- GRANT (owner o):
  - If req[o]=0 at an edge, gnt=0 next cycle; go to RELEASE.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD, gnt=0 next cycle and expired=1 for that one cycle; go to RELEASE.
  - Else stay in GRANT; hold_cnt++ (saturating); gnt is unchanged.
  - Requests from other clients never pre-empt the owner.
- RELEASE:
  - Lasts exactly one cycle with gnt=0.
  - Arbitration is evaluated on req sampled in this cycle. If req!=0, go to GRANT with the new winner from the next cycle; else go to IDLE.
  - Minimum gap between two grants is therefore exactly one zero cycle.
- Fixed priority (rr_en=0): search order 3,2,1,0.
  - A timed-out owner may win again immediately if it is still the highest requester. This is intended.
- Round-robin (rr_en=1): search order descending modulo 4, starting at (last_id-1): last_id-1, last_id-2, last_id-3, last_id.
  - After reset (last_id=0) the order is 3,2,1,0, identical to fixed mode.
  - last_id updates only when a grant is issued.
- rr_en is sampled only at arbitration points (IDLE or RELEASE). Changing it during GRANT has no effect until the next arbitration.
- gnt is always one-hot or zero and never changes owner without an intervening zero cycle.
- gnt_id and busy are registered alongside gnt and remain consistent with it.
- req bits that rise and fall between arbitration points are ignored; there is no request memory.
- MAX_HOLD=1: each grant lasts exactly one cycle and is followed by an expired pulse.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, GRANT, RELEASE};
  - constant NREQ=4;
  - constant IDW=2.
- Sub-module prio_pick4 (combinational):
  - inputs req[3:0] and start[1:0];
  - outputs any and win[1:0];
  - descending circular search beginning at start.
- The controller drives start=3 in fixed mode and start=last_id-1 in RR mode.

Test Plan:
- Reset, then req=4'b0101, rr_en=0 -> gnt=4'b0100, gnt_id=2 one cycle later; busy=1; expired=0.
- Client 2 holds req for 20 cycles, MAX_HOLD=8, req[0]=1 throughout:
  - gnt=4'b0100 for 8 cycles;
  - gnt=0 with expired=1 for 1 cycle;
  - fixed mode re-grants client 2 (4'b0100).
- Same stimulus with rr_en=1 -> after the 8-cycle grant and the dead cycle, gnt=4'b0001 (client 0).
- RR fairness with req=4'b1111 constant, MAX_HOLD=2 -> owner sequence 3,2,1,0,3 with pattern 2 grant cycles, 1 zero cycle.
- Owner drops req after 3 cycles while others are idle -> gnt=0, state RELEASE then IDLE; no expired pulse.
- rst asserted mid-grant with req=4'b1000 -> gnt=0, busy=0, gnt_id=0 the next cycle; after rst deasserts, a grant to client 3 follows one cycle later.

Source files
------------

// File: rtl/arb4_ctrl_pkg.sv
// Shared definitions for the four-client arbiter: state encoding, sizes and
// a small one-hot helper used when a winner is turned into a grant vector.
package arb_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Turns a client index into its one-hot grant pattern.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb4_ctrl_if.sv
// Bundle of request/grant signals shared between the clients (master side)
// and the arbiter (slave side). Clock and reset travel as plain ports.
interface arb4_ctrl_if;
  import arb_pkg::*;

  logic [NREQ-1:0] req;
  logic            rr_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            expired;

  modport master (
    output req,
    output rr_en,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  expired
  );

  modport slave (
    input  req,
    input  rr_en,
    output gnt,
    output gnt_id,
    output busy,
    output expired
  );

endinterface

// File: rtl/arb4_ctrl_prio_pick4.sv
// Combinational priority picker: scans the four request bits in descending
// circular order beginning at 'start' and reports the first one found.
module prio_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic            any,
  output logic [IDW-1:0]  win
);

  logic [IDW-1:0] w_idx;

  // Walk the order from the lowest-precedence slot up to 'start' so the last
  // hit written is the highest-precedence requester.
  always_comb begin
    any   = 1'b0;
    win   = start;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = start - IDW'(k);
      if (req[w_idx]) begin
        any = 1'b1;
        win = w_idx;
      end
    end
  end

endmodule

// File: rtl/arb4_ctrl.sv
// Four-client arbiter with fixed or round-robin priority, bounded hold time
// and a mandatory one-cycle dead gap between successive owners.
module arb4_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  arb4_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam bit               HOLD_EN    = (MAX_HOLD != 0);

  state_t          r_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [IDW-1:0]  r_last_id;
  logic [NREQ-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;
  logic            r_busy;
  logic            r_expired;

  logic [IDW-1:0]  w_start;
  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic            w_owner_req;

  // Fixed mode always searches from client 3; round-robin starts just below
  // the most recent owner so it gets served last next time.
  assign w_start     = bus.rr_en ? (r_last_id - IDW'(1)) : IDW'(NREQ - 1);
  assign w_owner_req = bus.req[r_gnt_id];

  prio_pick4 u_pick (
    .req   (bus.req),
    .start (w_start),
    .any   (w_any),
    .win   (w_win)
  );

  // Single control process: arbitration in IDLE/RELEASE, hold/timeout in
  // GRANT; every output is registered here so it lines up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_last_id  <= '0;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_busy     <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        IDLE, RELEASE: begin
          if (w_any) begin
            r_state    <= GRANT;
            r_gnt      <= onehot(w_win);
            r_gnt_id   <= w_win;
            r_busy     <= 1'b1;
            r_hold_cnt <= CNT_W'(1);
            r_last_id  <= w_win;
          end else begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (!w_owner_req) begin
            r_state <= RELEASE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else if (HOLD_EN && (r_hold_cnt == HOLD_LIMIT)) begin
            r_state   <= RELEASE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_expired <= 1'b1;
          end else if (r_hold_cnt != CNT_MAX) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign bus.expired = r_expired;

endmodule

// File: tb/tb_arb4_ctrl.sv
// Bench for arb4_ctrl: two instances (hold limits 8 and 2) share one
// stimulus stream; an owner/hold-count model predicts every cycle and a few
// directed sequences pin the model with hand-worked grant patterns.
module tb_arb4_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tbReq;
  logic       tbRr;

  int vectors     = 0;
  int miscompares = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  arb4_ctrl_if ifA ();
  arb4_ctrl_if ifB ();

  assign ifA.req   = tbReq;
  assign ifA.rr_en = tbRr;
  assign ifB.req   = tbReq;
  assign ifB.rr_en = tbRr;

  arb4_ctrl #(.MAX_HOLD(8), .CNT_W(8)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  arb4_ctrl #(.MAX_HOLD(2), .CNT_W(8)) dutB (.clk(clk), .rst(rst), .bus(ifB));

  // Model state per instance: current owner (-1 = none), cycles held so far,
  // last granted client, and whether the previous edge revoked on timeout.
  int mOwner[2];
  int mHeld[2];
  int mLast[2];
  int mId[2];
  bit mExp[2];
  int holdLim[2] = '{8, 2};
  bit modelValid = 1'b0;

  // Advance the model on every rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mOwner[d] = -1;
        mHeld[d]  = 0;
        mLast[d]  = 0;
        mId[d]    = 0;
        mExp[d]   = 1'b0;
      end else begin
        mExp[d] = 1'b0;
        if (mOwner[d] >= 0) begin
          if (!tbReq[mOwner[d]]) begin
            mOwner[d] = -1;
          end else if (holdLim[d] != 0 && mHeld[d] == holdLim[d]) begin
            mOwner[d] = -1;
            mExp[d]   = 1'b1;
          end else if (mHeld[d] < 255) begin
            mHeld[d] = mHeld[d] + 1;
          end
        end else begin
          int start;
          int cand;
          bit found;
          start = tbRr ? (mLast[d] + 3) % 4 : 3;
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            cand = (start - k + 4) % 4;
            if (!found && tbReq[cand]) begin
              found     = 1'b1;
              mOwner[d] = cand;
              mHeld[d]  = 1;
              mLast[d]  = cand;
              mId[d]    = cand;
            end
          end
        end
      end
    end
    if (rst) modelValid = 1'b1;
  end

  task automatic checkVal(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] dutGnt(input int d);
    return (d == 0) ? ifA.gnt : ifB.gnt;
  endfunction
  function automatic int dutId(input int d);
    return (d == 0) ? int'(ifA.gnt_id) : int'(ifB.gnt_id);
  endfunction
  function automatic bit dutBusy(input int d);
    return (d == 0) ? ifA.busy : ifB.busy;
  endfunction
  function automatic bit dutExp(input int d);
    return (d == 0) ? ifA.expired : ifB.expired;
  endfunction

  // Compare both instances against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (modelValid) begin
      for (int d = 0; d < 2; d++) begin
        int eg;
        string p;
        p  = (d == 0) ? "A" : "B";
        eg = (mOwner[d] >= 0) ? (1 << mOwner[d]) : 0;
        checkVal({p, ".gnt"}, int'(dutGnt(d)), eg);
        checkVal({p, ".busy"}, int'(dutBusy(d)), (mOwner[d] >= 0) ? 1 : 0);
        checkVal({p, ".expired"}, int'(dutExp(d)), int'(mExp[d]));
        if (mOwner[d] >= 0) checkVal({p, ".gnt_id"}, dutId(d), mOwner[d]);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input bit rr, input bit rs);
    tbReq = r;
    tbRr  = rr;
    rst   = rs;
  endtask

  task automatic checkOutput(input string tag, input int d, input logic [3:0] eg,
                             input bit eb, input int eid, input bit chkId, input bit ee);
    checkVal({tag, ".gnt"}, int'(dutGnt(d)), int'(eg));
    checkVal({tag, ".busy"}, int'(dutBusy(d)), int'(eb));
    checkVal({tag, ".expired"}, int'(dutExp(d)), int'(ee));
    if (chkId) checkVal({tag, ".gnt_id"}, dutId(d), eid);
  endtask

  // Directed sequences with literal expectations, then a long random run.
  initial begin
    applyStimulus(4'b0000, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rstA", 0, 4'b0000, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("rstB", 1, 4'b0000, 1'b0, 0, 1'b1, 1'b0);

    // Fixed priority: client 2 beats 0, holds 8, expires, wins again.
    applyStimulus(4'b0101, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 8)       checkOutput("fixHold", 0, 4'b0100, 1'b1, 2, 1'b1, 1'b0);
      else if (i == 9)  checkOutput("fixDead", 0, 4'b0000, 1'b0, 0, 1'b0, 1'b1);
      else              checkOutput("fixRegrant", 0, 4'b0100, 1'b1, 2, 1'b1, 1'b0);
    end

    // Round-robin: same requests, client 0 gets the next turn.
    applyStimulus(4'b0101, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(4'b0101, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 8)       checkOutput("rrHold", 0, 4'b0100, 1'b1, 2, 1'b1, 1'b0);
      else if (i == 9)  checkOutput("rrDead", 0, 4'b0000, 1'b0, 0, 1'b0, 1'b1);
      else              checkOutput("rrNext", 0, 4'b0001, 1'b1, 0, 1'b1, 1'b0);
    end

    // Round-robin fairness on the hold-2 instance: owners 3,2,1,0,3.
    applyStimulus(4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      int g;
      int ph;
      int own;
      logic [3:0] oh;
      @(negedge clk);
      g   = (i - 1) / 3;
      ph  = (i - 1) % 3;
      own = (3 - g + 4) % 4;
      oh  = 4'(1 << own);
      if (ph < 2) checkOutput("rrFair", 1, oh, 1'b1, own, 1'b1, 1'b0);
      else        checkOutput("rrFairGap", 1, 4'b0000, 1'b0, 0, 1'b0, 1'b1);
    end

    // Owner releases voluntarily after three cycles: no expired pulse.
    applyStimulus(4'b0010, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput("dropHold", 0, 4'b0010, 1'b1, 1, 1'b1, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);
    for (int i = 4; i <= 5; i++) begin
      @(negedge clk);
      checkOutput("dropIdle", 0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
    end

    // Reset in the middle of a grant to client 3.
    applyStimulus(4'b1000, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("preRst", 0, 4'b1000, 1'b1, 3, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("midRst", 0, 4'b0000, 1'b0, 0, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postRst", 0, 4'b1000, 1'b1, 3, 1'b1, 1'b0);

    // Random traffic: sticky request bits, occasional mode flips and resets.
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] r;
      bit rr;
      bit rs;
      r = tbReq;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      rr = ($urandom_range(0, 15) == 0) ? ~tbRr : tbRr;
      rs = ($urandom_range(0, 299) == 0);
      applyStimulus(r, rr, rs);
      @(negedge clk);
    end

    applyStimulus(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
